display_scan_driver: RTL

Drives the board's eight-digit multiplexed seven-segment display from the 32-bit `hexDisplay` word produced by the debug display mux. The block sits directly downstream of that mux. It captures the word into a shadow register once per scan frame, so the display never tears. It then time-multiplexes one hex nibble per digit onto a shared active-low segment bus, with optional leading-zero blanking and a freeze control for single-stepping the processor.

---
 rtl/display_scan_driver.sv | 127 ++++++++++++
 1 files changed

// File: rtl/display_scan_driver.sv
// display_scan_driver: scans a 32-bit hex word onto an eight-digit multiplexed
// seven-segment display. The word is captured into a shadow register once per
// frame so the display never tears. One nibble is shown per digit on a shared
// active-low segment bus, with optional leading-zero blanking and a frame hold.
//
// Ports:
//   Clock       system clock, rising edge
//   Resetn      asynchronous active-low reset
//   hexDisplay  word to show; nibble i drives digit i (digit 0 rightmost)
//   hold        suppresses the frame-boundary capture when high
//   blank_lz    enables leading-zero blanking when high
//   seg         segment drive, active-low, seg[0]=a .. seg[6]=g (registered)
//   digit_en    digit anode enables, active-low, one-hot (registered)
//   frame_done  one-cycle pulse on each frame boundary (registered)
module display_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [31:0] hexDisplay,
  input  logic        hold,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [7:0]  digit_en,
  output logic        frame_done
);

  localparam int unsigned DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned DIGITS   = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;

  logic [DIV_W-1:0]  div_q,    div_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [SEG_W-1:0]  seg_d;
  logic [DIGITS-1:0] digit_en_d;
  logic              frame_done_d;

  logic              tick;
  logic              wrap;
  logic [WORD_W-1:0] upper;
  logic [3:0]        nib;
  logic              blank;

  // Active-low seven-segment encoding of one hex nibble.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] n);
    logic [SEG_W-1:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    tick         = 1'b0;
    wrap         = 1'b0;
    div_d        = div_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    upper        = '0;
    nib          = '0;
    blank        = 1'b0;
    seg_d        = SEG_OFF;
    digit_en_d   = '1;

    tick = (div_q == DIV_LAST);
    wrap = tick && (idx_q == 3'd7);

    div_d = tick ? '0 : div_q + DIV_W'(1);
    idx_d = tick ? idx_q + IDX_W'(1) : idx_q;

    // Capture only at the frame boundary so a frame never mixes two words.
    if (wrap && !hold) begin
      shadow_d = hexDisplay;
    end
    frame_done_d = wrap;

    // Nibbles at and above the current digit; all-zero means leading zeros.
    upper = shadow_q >> {idx_q, 2'b00};
    nib   = upper[3:0];
    blank = blank_lz && (idx_q != 3'd0) && (upper == '0);

    seg_d      = blank ? SEG_OFF : hex_to_seg(nib);
    digit_en_d = ~(DIGITS'(1) << idx_q);
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      div_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      seg        <= SEG_OFF;
      digit_en   <= '1;
      frame_done <= 1'b0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      seg        <= seg_d;
      digit_en   <= digit_en_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
